// File: rtl/wb_master_bridge_if.sv
// Processor-side and Wishbone-side signal bundle for wb_master_bridge.
// The master modport is the bridge's view; the slave modport is the view of whatever drives it.
interface wb_master_bridge_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0]   proc_addr;
  logic [DATA_W-1:0]   proc_wdata;
  logic                proc_write;
  logic                proc_read;
  logic [2:0]          proc_op;
  logic [DATA_W-1:0]   proc_rdata;
  logic                proc_stall_pipl;
  logic                proc_err;

  logic [ADDR_W-1:0]   wb_adr_o;
  logic [DATA_W-1:0]   wb_dat_o;
  logic [DATA_W/8-1:0] wb_sel_o;
  logic                wb_we_o;
  logic                wb_cyc_o;
  logic                wb_stb_o;
  logic [DATA_W-1:0]   wb_dat_i;
  logic                wb_ack_i;
  logic                wb_err_i;

  modport master (
    input  proc_addr, proc_wdata, proc_write, proc_read, proc_op,
    output proc_rdata, proc_stall_pipl, proc_err,
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  modport slave (
    output proc_addr, proc_wdata, proc_write, proc_read, proc_op,
    input  proc_rdata, proc_stall_pipl, proc_err,
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );
endinterface

// File: rtl/wb_master_bridge.sv
// Processor load/store to Wishbone single-access bridge with lane alignment and sign extension.
// Optional bus timeout is enabled by defining WB_MASTER_TIMEOUT_EN.
module wb_master_bridge #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  wb_master_bridge_if.master io_bus
);

  localparam int SEL_W = DATA_W / 8;
  localparam int OFF_W = $clog2(SEL_W);

  if (!(DATA_W == 32 || DATA_W == 64) || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_param
    $error("wb_master_bridge: DATA_W must be 32 or 64 and TIMEOUT within 1..65535");
  end

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_adr;
  logic [DATA_W-1:0] r_dat;
  logic [SEL_W-1:0]  r_sel;
  logic              r_we;
  logic              r_cyc;
  logic              r_stb;
  logic [2:0]        r_op;
  logic [OFF_W-1:0]  r_off;
  logic              r_err;
  logic [DATA_W-1:0] r_rdata;

  logic              w_req;
  logic [OFF_W-1:0]  w_off;
  logic [SEL_W-1:0]  w_sizeMask;
  logic              w_misaligned;
  logic              w_illegal;
  logic              w_bad;
  logic              w_timeout;
  logic              w_busEnd;

  // Picks the addressed lane out of the bus word, then sign- or zero-extends it.
  function automatic logic [DATA_W-1:0] alignLoad(input logic [DATA_W-1:0] d,
                                                  input logic [OFF_W-1:0]  off,
                                                  input logic [2:0]        op);
    logic [DATA_W-1:0] s;
    logic [DATA_W-1:0] r;
    logic              fill;
    int                bits;
    s = d >> {off, 3'b000};
    case (op[1:0])
      2'b00:   begin bits = 8;      fill = s[7];        end
      2'b01:   begin bits = 16;     fill = s[15];       end
      2'b10:   begin bits = 32;     fill = s[31];       end
      default: begin bits = DATA_W; fill = s[DATA_W-1]; end
    endcase
    if (op[2]) fill = 1'b0;
    for (int i = 0; i < DATA_W; i++) r[i] = (i < bits) ? s[i] : fill;
    return r;
  endfunction

  assign w_req = io_bus.proc_read | io_bus.proc_write;
  assign w_off = io_bus.proc_addr[OFF_W-1:0];

  always_comb begin
    w_sizeMask   = '0;
    w_misaligned = 1'b0;
    case (io_bus.proc_op[1:0])
      2'b00: w_sizeMask = SEL_W'(8'h01);
      2'b01: begin
        w_sizeMask   = SEL_W'(8'h03);
        w_misaligned = io_bus.proc_addr[0];
      end
      2'b10: begin
        w_sizeMask   = SEL_W'(8'h0F);
        w_misaligned = |io_bus.proc_addr[1:0];
      end
      default: begin
        w_sizeMask   = SEL_W'(8'hFF);
        w_misaligned = |io_bus.proc_addr[2:0];
      end
    endcase
  end

  // Doubleword and WU only exist on a 64-bit bus; 111 is never a valid access size.
  assign w_illegal = (io_bus.proc_op == 3'b111) ||
                     ((DATA_W == 32) && (io_bus.proc_op == 3'b011 || io_bus.proc_op == 3'b110));
  assign w_bad     = w_misaligned | w_illegal;
  assign w_busEnd  = io_bus.wb_ack_i | io_bus.wb_err_i | w_timeout;

`ifdef WB_MASTER_TIMEOUT_EN
  logic [15:0] r_cnt;

  assign w_timeout = ~io_bus.wb_ack_i & ~io_bus.wb_err_i & (r_cnt == 16'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_state == IDLE && w_req) begin
      r_cnt <= '0;
    end else if (r_state == BUS && !(io_bus.wb_ack_i || io_bus.wb_err_i)) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_req) w_next = w_bad ? DONE : BUS;
      BUS:     if (w_busEnd) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Rejected requests skip the bus entirely; only the error flag travels to DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_adr   <= '0;
      r_dat   <= '0;
      r_sel   <= '0;
      r_we    <= 1'b0;
      r_cyc   <= 1'b0;
      r_stb   <= 1'b0;
      r_op    <= '0;
      r_off   <= '0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_op  <= io_bus.proc_op;
            r_off <= w_off;
            r_err <= w_bad;
            if (!w_bad) begin
              r_adr <= {io_bus.proc_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              r_dat <= io_bus.proc_wdata << {w_off, 3'b000};
              r_sel <= io_bus.proc_write ? (w_sizeMask << w_off) : '1;
              r_we  <= io_bus.proc_write;
              r_cyc <= 1'b1;
              r_stb <= 1'b1;
            end
          end
        end
        BUS: begin
          if (w_busEnd) begin
            r_cyc <= 1'b0;
            r_stb <= 1'b0;
            r_err <= io_bus.wb_err_i | w_timeout;
            if (io_bus.wb_ack_i && !io_bus.wb_err_i && !r_we)
              r_rdata <= alignLoad(io_bus.wb_dat_i, r_off, r_op);
          end
        end
        default: ;
      endcase
    end
  end

  assign io_bus.proc_stall_pipl = w_req & (r_state != DONE);
  assign io_bus.proc_err        = (r_state == DONE) & r_err;
  assign io_bus.proc_rdata      = r_rdata;
  assign io_bus.wb_adr_o        = r_adr;
  assign io_bus.wb_dat_o        = r_dat;
  assign io_bus.wb_sel_o        = r_sel;
  assign io_bus.wb_we_o         = r_we;
  assign io_bus.wb_cyc_o        = r_cyc;
  assign io_bus.wb_stb_o        = r_stb;

endmodule

// File: tb/tb_wb_master_bridge.sv
// Directed bench for wb_master_bridge: a 32-bit instance (TIMEOUT=4) and a 64-bit instance.
module tb_wb_master_bridge;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic rst64 = 1'b1;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  wb_master_bridge_if #(.DATA_W(32), .ADDR_W(32)) b32 ();
  wb_master_bridge_if #(.DATA_W(64), .ADDR_W(32)) b64 ();

  wb_master_bridge #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) u_dut32 (
    .clk(clk), .rst(rst), .io_bus(b32)
  );

  wb_master_bridge #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(255)) u_dut64 (
    .clk(clk), .rst(rst64), .io_bus(b64)
  );

  task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] op,
                               input logic [31:0] addr, input logic [31:0] wdata);
    b32.proc_read  = rd;
    b32.proc_write = wr;
    b32.proc_op    = op;
    b32.proc_addr  = addr;
    b32.proc_wdata = wdata;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    b32.wb_dat_i = '0; b32.wb_ack_i = 1'b0; b32.wb_err_i = 1'b0;
    b64.proc_read = 1'b0; b64.proc_write = 1'b0; b64.proc_op = 3'b000;
    b64.proc_addr = '0; b64.proc_wdata = '0;
    b64.wb_dat_i = '0; b64.wb_ack_i = 1'b0; b64.wb_err_i = 1'b0;

    // Reset holds everything idle even with a request pending
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
    repeat (2) @(negedge clk);
    checkOutput("rst_cyc",   b32.wb_cyc_o,   64'h0);
    checkOutput("rst_stb",   b32.wb_stb_o,   64'h0);
    checkOutput("rst_we",    b32.wb_we_o,    64'h0);
    checkOutput("rst_sel",   b32.wb_sel_o,   64'h0);
    checkOutput("rst_adr",   b32.wb_adr_o,   64'h0);
    checkOutput("rst_dat",   b32.wb_dat_o,   64'h0);
    checkOutput("rst_rdata", b32.proc_rdata, 64'h0);
    checkOutput("rst_err",   b32.proc_err,   64'h0);
    checkOutput("rst_cyc64", b64.wb_cyc_o,   64'h0);

    // LW 0x100, ack on first BUS cycle
    rst = 1'b0; rst64 = 1'b0;
    checkOutput("lw_stall_idle", b32.proc_stall_pipl, 64'h1);
    @(negedge clk);
    checkOutput("lw_cyc",   b32.wb_cyc_o,        64'h1);
    checkOutput("lw_stb",   b32.wb_stb_o,        64'h1);
    checkOutput("lw_we",    b32.wb_we_o,         64'h0);
    checkOutput("lw_sel",   b32.wb_sel_o,        64'hF);
    checkOutput("lw_adr",   b32.wb_adr_o,        64'h100);
    checkOutput("lw_stall", b32.proc_stall_pipl, 64'h1);
    b32.wb_ack_i = 1'b1; b32.wb_dat_i = 32'hDEADBEEF;
    @(negedge clk);
    b32.wb_ack_i = 1'b0;
    checkOutput("lw_done_stall", b32.proc_stall_pipl, 64'h0);
    checkOutput("lw_rdata",      b32.proc_rdata,      64'hDEADBEEF);
    checkOutput("lw_err",        b32.proc_err,        64'h0);
    checkOutput("lw_cyc_drop",   b32.wb_cyc_o,        64'h0);
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("lw_rdata_hold", b32.proc_rdata, 64'hDEADBEEF);

    // SB 0x103
    applyStimulus(1'b0, 1'b1, 3'b000, 32'h103, 32'h000000A5);
    @(negedge clk);
    checkOutput("sb_sel", b32.wb_sel_o, 64'h8);
    checkOutput("sb_dat", b32.wb_dat_o, 64'hA5000000);
    checkOutput("sb_adr", b32.wb_adr_o, 64'h100);
    checkOutput("sb_we",  b32.wb_we_o,  64'h1);
    checkOutput("sb_cyc", b32.wb_cyc_o, 64'h1);
    b32.wb_ack_i = 1'b1;
    @(negedge clk);
    b32.wb_ack_i = 1'b0;
    checkOutput("sb_err",   b32.proc_err,   64'h0);
    checkOutput("sb_rdata", b32.proc_rdata, 64'hDEADBEEF);
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);

    // LH 0x101 misaligned: straight to DONE, no bus cycle
    applyStimulus(1'b1, 1'b0, 3'b001, 32'h101, 32'h0);
    @(negedge clk);
    checkOutput("lh_mis_cyc",   b32.wb_cyc_o,        64'h0);
    checkOutput("lh_mis_err",   b32.proc_err,        64'h1);
    checkOutput("lh_mis_stall", b32.proc_stall_pipl, 64'h0);
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("lh_mis_err_idle", b32.proc_err, 64'h0);

    // LB 0x102, ack and err together: err wins, data discarded
    applyStimulus(1'b1, 1'b0, 3'b000, 32'h102, 32'h0);
    @(negedge clk);
    checkOutput("lb_ae_cyc", b32.wb_cyc_o, 64'h1);
    checkOutput("lb_ae_adr", b32.wb_adr_o, 64'h100);
    b32.wb_ack_i = 1'b1; b32.wb_err_i = 1'b1; b32.wb_dat_i = 32'h00800000;
    @(negedge clk);
    b32.wb_ack_i = 1'b0; b32.wb_err_i = 1'b0;
    checkOutput("lb_ae_err",   b32.proc_err,   64'h1);
    checkOutput("lb_ae_rdata", b32.proc_rdata, 64'hDEADBEEF);
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);

    // Same LB with ack only: byte 2 = 0x80, sign-extended
    applyStimulus(1'b1, 1'b0, 3'b000, 32'h102, 32'h0);
    @(negedge clk);
    b32.wb_ack_i = 1'b1; b32.wb_dat_i = 32'h00800000;
    @(negedge clk);
    b32.wb_ack_i = 1'b0;
    checkOutput("lb_err",   b32.proc_err,   64'h0);
    checkOutput("lb_rdata", b32.proc_rdata, 64'hFFFFFF80);
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);

    // LHU 0x102: upper half 0x8001 zero-extended
    applyStimulus(1'b1, 1'b0, 3'b101, 32'h102, 32'h0);
    @(negedge clk);
    b32.wb_ack_i = 1'b1; b32.wb_dat_i = 32'h80010000;
    @(negedge clk);
    b32.wb_ack_i = 1'b0;
    checkOutput("lhu_rdata", b32.proc_rdata, 64'h00008001);
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);

    // SH 0x102; request inputs changed mid-BUS must not leak through
    applyStimulus(1'b0, 1'b1, 3'b001, 32'h102, 32'h00001234);
    @(negedge clk);
    checkOutput("sh_sel", b32.wb_sel_o, 64'hC);
    checkOutput("sh_dat", b32.wb_dat_o, 64'h12340000);
    applyStimulus(1'b0, 1'b1, 3'b010, 32'h200, 32'h55555555);
    b32.wb_ack_i = 1'b1;
    @(negedge clk);
    b32.wb_ack_i = 1'b0;
    checkOutput("sh_adr_held", b32.wb_adr_o, 64'h100);
    checkOutput("sh_sel_held", b32.wb_sel_o, 64'hC);
    checkOutput("sh_dat_held", b32.wb_dat_o, 64'h12340000);
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);

    // Read and write both high: treated as SW
    applyStimulus(1'b1, 1'b1, 3'b010, 32'h108, 32'hCAFEF00D);
    @(negedge clk);
    checkOutput("rw_we",  b32.wb_we_o,  64'h1);
    checkOutput("rw_sel", b32.wb_sel_o, 64'hF);
    checkOutput("rw_dat", b32.wb_dat_o, 64'hCAFEF00D);
    checkOutput("rw_adr", b32.wb_adr_o, 64'h108);
    b32.wb_ack_i = 1'b1;
    @(negedge clk);
    b32.wb_ack_i = 1'b0;
    checkOutput("rw_err", b32.proc_err, 64'h0);
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);

    // LD on a 32-bit bus is an illegal op
    applyStimulus(1'b1, 1'b0, 3'b011, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("ld32_cyc", b32.wb_cyc_o, 64'h0);
    checkOutput("ld32_err", b32.proc_err, 64'h1);
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);

    // Stray ack/err while idle
    b32.wb_ack_i = 1'b1; b32.wb_err_i = 1'b1;
    @(negedge clk);
    b32.wb_ack_i = 1'b0; b32.wb_err_i = 1'b0;
    checkOutput("stray_cyc", b32.wb_cyc_o, 64'h0);
    checkOutput("stray_err", b32.proc_err, 64'h0);
    @(negedge clk);
    checkOutput("stray_err2", b32.proc_err, 64'h0);

`ifdef WB_MASTER_TIMEOUT_EN
    // Slave never answers: four BUS cycles, then DONE with error
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h200, 32'h0);
    @(negedge clk);
    checkOutput("to_cyc_first", b32.wb_cyc_o, 64'h1);
    repeat (3) @(negedge clk);
    checkOutput("to_cyc_last", b32.wb_cyc_o, 64'h1);
    @(negedge clk);
    checkOutput("to_cyc_drop", b32.wb_cyc_o,        64'h0);
    checkOutput("to_err",      b32.proc_err,        64'h1);
    checkOutput("to_stall",    b32.proc_stall_pipl, 64'h0);
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("to_idle_err", b32.proc_err, 64'h0);
    checkOutput("to_idle_cyc", b32.wb_cyc_o, 64'h0);
`else
    // Without the timeout the bridge waits for as long as the slave takes
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h200, 32'h0);
    @(negedge clk);
    repeat (10) @(negedge clk);
    checkOutput("wait_cyc",   b32.wb_cyc_o,        64'h1);
    checkOutput("wait_stall", b32.proc_stall_pipl, 64'h1);
    b32.wb_ack_i = 1'b1; b32.wb_dat_i = 32'h13579BDF;
    @(negedge clk);
    b32.wb_ack_i = 1'b0;
    checkOutput("wait_err",   b32.proc_err,   64'h0);
    checkOutput("wait_rdata", b32.proc_rdata, 64'h13579BDF);
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
`endif

    // 64-bit LD 0x8
    b64.proc_read = 1'b1; b64.proc_op = 3'b011; b64.proc_addr = 32'h8;
    @(negedge clk);
    checkOutput("ld64_sel", b64.wb_sel_o, 64'hFF);
    checkOutput("ld64_adr", b64.wb_adr_o, 64'h8);
    b64.wb_ack_i = 1'b1; b64.wb_dat_i = 64'h0123456789ABCDEF;
    @(negedge clk);
    b64.wb_ack_i = 1'b0;
    checkOutput("ld64_rdata", b64.proc_rdata, 64'h0123456789ABCDEF);
    checkOutput("ld64_err",   b64.proc_err,   64'h0);
    b64.proc_read = 1'b0;
    @(negedge clk);

    // 64-bit LWU 0x4: upper word, zero-extended
    b64.proc_read = 1'b1; b64.proc_op = 3'b110; b64.proc_addr = 32'h4;
    @(negedge clk);
    checkOutput("lwu64_adr", b64.wb_adr_o, 64'h0);
    b64.wb_ack_i = 1'b1; b64.wb_dat_i = 64'h89ABCDEF01234567;
    @(negedge clk);
    b64.wb_ack_i = 1'b0;
    checkOutput("lwu64_rdata", b64.proc_rdata, 64'h0000000089ABCDEF);
    b64.proc_read = 1'b0;
    @(negedge clk);

    // Reset pulsed mid-BUS drops cyc/stb without waiting for a clock edge
    b64.proc_read = 1'b1; b64.proc_op = 3'b011; b64.proc_addr = 32'h10;
    @(negedge clk);
    checkOutput("rstbus_cyc_before", b64.wb_cyc_o, 64'h1);
    b64.proc_read = 1'b0;
    #2 rst64 = 1'b1;
    #1;
    checkOutput("rstbus_cyc_async", b64.wb_cyc_o, 64'h0);
    checkOutput("rstbus_stb_async", b64.wb_stb_o, 64'h0);
    #1 rst64 = 1'b0;
    @(negedge clk);
    checkOutput("rstbus_err",   b64.proc_err,        64'h0);
    checkOutput("rstbus_rdata", b64.proc_rdata,      64'h0);
    checkOutput("rstbus_stall", b64.proc_stall_pipl, 64'h0);
    checkOutput("rstbus_cyc",   b64.wb_cyc_o,        64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_master_bridge.md
WB_MASTER_BRIDGE -- requirements
Module: wb_master_bridge

Interface
REQ-001 The block SHALL have these parameters:
- DATA_W, 32, bus data width; legal values 32 or 64.
- ADDR_W, 32, address width.
- TIMEOUT, 255, maximum wait cycles for ack/err; range 1..65535.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- proc_addr  in  ADDR_W  processor byte address.
- proc_wdata  in  DATA_W  store data, right-justified.
- proc_write  in  1  store request.
- proc_read  in  1  load request.
- proc_op  in  3  funct3 access size/sign.
- proc_rdata  out  DATA_W  aligned, extended load data.
- proc_stall_pipl  out  1  hold pipeline.
- proc_err  out  1  access failed; pulses with completion.
- wb_adr_o  out  ADDR_W  Wishbone address, lane-aligned.
- wb_dat_o  out  DATA_W  Wishbone write data, lane-shifted.
- wb_sel_o  out  DATA_W/8  byte enables.
- wb_we_o  out  1  write enable.
- wb_cyc_o  out  1  cycle valid.
- wb_stb_o  out  1  strobe.
- wb_dat_i  in  DATA_W  read data.
- wb_ack_i  in  1  acknowledge.
- wb_err_i  in  1  bus error.

Function
REQ-003 The block SHALL have an FSM with states IDLE, BUS and DONE; all wb_* outputs SHALL be registered.
- IDLE: on proc_read|proc_write, latch address, op, we, sel and shifted data; go to BUS with cyc=stb=1. A misaligned request goes straight to DONE with the error flag set and issues no bus cycle.
- BUS: on wb_err_i or wb_ack_i, drop cyc/stb next edge, latch wb_dat_i, go to DONE.
- DONE: hold one cycle, then go to IDLE.

REQ-004 proc_stall_pipl SHALL equal (proc_read|proc_write) & (state != DONE).
- Minimum request-to-release latency is 2 cycles: request, BUS with ack, then DONE.

REQ-005 In DONE, proc_rdata SHALL present the latched data, lane-selected by offset addr[log2(DATA_W/8)-1:0], then sign- or zero-extended per proc_op.
- Ops: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- If DATA_W=64, also 011 D and 110 WU; these ops are illegal at DATA_W=32 and are flagged as errors.
- Outside DONE, proc_rdata SHALL hold its last value.

REQ-006 Stores SHALL set wb_sel_o to the size mask shifted by the lane offset, and wb_dat_o to proc_wdata shifted left by offset*8.
- Loads SHALL drive full wb_sel_o (all ones).

REQ-007 Misalignment SHALL mean: H with addr[0]!=0, W with addr[1:0]!=0, D with addr[2:0]!=0.

REQ-008 proc_err SHALL be 1 only in DONE, and only after wb_err_i, misalignment, an illegal op, or a timeout.

REQ-009 If wb_ack_i and wb_err_i are high in the same cycle, err SHALL win and the read data SHALL be discarded.

REQ-010 If proc_read and proc_write are both high, the request SHALL be treated as a write.

REQ-011 Request inputs SHALL be sampled only in IDLE; changes during BUS/DONE SHALL be ignored.

REQ-012 wb_ack_i or wb_err_i arriving in IDLE or DONE SHALL be ignored.

Reset
REQ-013 While rst=1, regardless of clk:
- state=IDLE;
- all wb_* outputs 0;
- proc_rdata 0, proc_err 0;
- timeout counter 0.

REQ-014 Reset asserted during BUS SHALL drop wb_cyc_o/wb_stb_o immediately (asynchronously); no completion SHALL be reported.

Configuration
REQ-015 With macro WB_MASTER_TIMEOUT_EN defined:
- a 16-bit counter SHALL clear on BUS entry and increment each BUS cycle without ack/err;
- when the count reaches TIMEOUT, the block SHALL drop cyc/stb, go to DONE and set proc_err=1.

REQ-016 Without WB_MASTER_TIMEOUT_EN, the counter SHALL not exist and BUS SHALL wait indefinitely.

Verification
REQ-017 DATA_W=32, LW addr 0x100, slave acks in the first BUS cycle with 0xDEADBEEF -> stall high 2 cycles, proc_rdata=0xDEADBEEF in DONE, proc_err=0.

REQ-018 SB addr 0x103, wdata 0x000000A5 -> wb_sel_o=4'b1000, wb_dat_o=0xA5000000, wb_adr_o=0x100, wb_we_o=1.

REQ-019 LH addr 0x101 -> no wb_cyc_o assertion, DONE after 1 cycle with proc_err=1.

REQ-020 LB addr 0x102, wb_dat_i=0x00800000, with ack and err asserted in the same cycle -> proc_err=1.
- Repeat with ack only -> proc_rdata=0xFFFFFF80.

REQ-021 WB_MASTER_TIMEOUT_EN defined, TIMEOUT=4, slave never acks -> cyc drops after 4 BUS cycles, proc_err=1, FSM returns to IDLE.

REQ-022 DATA_W=64, LD addr 0x8 with wb_dat_i=0x0123456789ABCDEF -> proc_rdata equal to that value.
- rst pulsed mid-BUS -> wb_cyc_o=0 in the same cycle.
